// File: rtl/spi_txn_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_txn_arbiter: round-robin sharing of one SPI master among NREQ users,  |
// | with per-device chip-select steering, completion and timeout reporting.   |
// | Rev 1.0                                                                   |
// +----------------------------------------------------------------------------+
module spi_txn_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 12,
  parameter int TIMEOUT = 4096,
  parameter int CS_GAP  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  input  logic [NREQ-1:0]         en_mask,
  input  logic                    m_cs,
  output logic                    m_new_data,
  output logic [DW-1:0]           m_din,
  output logic [NREQ-1:0]         dev_cs_n,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         err,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int c_idw = $clog2(NREQ);
  localparam int c_cw  = $clog2(TIMEOUT + CS_GAP + 1);

  localparam logic [c_idw-1:0] c_last     = c_idw'(NREQ - 1);
  localparam logic [c_idw-1:0] c_idx_one  = c_idw'(1);
  localparam logic [NREQ-1:0]  c_one      = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [c_cw-1:0]  c_cnt_one  = c_cw'(1);
  localparam logic [c_cw-1:0]  c_to_last  = c_cw'(TIMEOUT - 1);
  localparam logic [c_cw-1:0]  c_gap_last = c_cw'(CS_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_XFER   = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t             r_state, w_state;
  logic [c_cw-1:0]    r_cnt, w_cnt;
  logic [c_idw-1:0]   r_rr_ptr, w_rr_ptr;
  logic               r_cs_meta, r_cs_s;

  logic [NREQ-1:0]    w_pending;
  logic               w_found;
  logic [c_idw-1:0]   w_winner, w_cand;
  logic [DW-1:0]      w_slice;
  logic [NREQ-1:0]    w_sel;

  logic               w_new_data, w_busy;
  logic [DW-1:0]      w_din;
  logic [NREQ-1:0]    w_cs_n, w_ack, w_done, w_err;
  logic [c_idw-1:0]   w_grant_id;

  assign w_pending = req & en_mask;

  // Scan starts just after the last winner, so a re-requesting winner goes last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = r_rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (w_cand == c_last) w_cand = '0;
      else                  w_cand = w_cand + c_idx_one;
      if (!w_found && w_pending[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  always_comb begin
    w_slice = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner == c_idw'(i)) w_slice = req_data[i*DW +: DW];
    end
  end

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt + c_cnt_one;
    w_rr_ptr   = r_rr_ptr;
    w_grant_id = grant_id;
    w_din      = m_din;
    w_new_data = m_new_data;
    w_cs_n     = dev_cs_n;
    w_ack      = '0;
    w_done     = '0;
    w_err      = '0;
    w_busy     = busy;
    w_sel      = c_one << grant_id;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state    = S_LAUNCH;
          w_cnt      = '0;
          w_rr_ptr   = w_winner;
          w_grant_id = w_winner;
          w_din      = w_slice;
          w_new_data = 1'b1;
          w_busy     = 1'b1;
          w_ack      = c_one << w_winner;
        end
      end
      S_LAUNCH: begin
        if (!r_cs_s) begin
          w_state    = S_XFER;
          w_cnt      = '0;
          w_new_data = 1'b0;
          w_cs_n     = ~w_sel;
        end else if (r_cnt == c_to_last) begin
          w_state    = S_GAP;
          w_cnt      = '0;
          w_new_data = 1'b0;
          w_cs_n     = '1;
          w_err      = w_sel;
        end
      end
      S_XFER: begin
        if (r_cs_s) begin
          w_state = S_GAP;
          w_cnt   = '0;
          w_cs_n  = '1;
          w_done  = w_sel;
        end else if (r_cnt == c_to_last) begin
          w_state = S_GAP;
          w_cnt   = '0;
          w_cs_n  = '1;
          w_err   = w_sel;
        end
      end
      S_GAP: begin
        if (r_cnt == c_gap_last) begin
          w_state = S_IDLE;
          w_busy  = 1'b0;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rr_ptr   <= c_last;
      r_cs_meta  <= 1'b1;
      r_cs_s     <= 1'b1;
      m_new_data <= 1'b0;
      m_din      <= '0;
      dev_cs_n   <= '1;
      ack        <= '0;
      done       <= '0;
      err        <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_rr_ptr   <= w_rr_ptr;
      r_cs_meta  <= m_cs;
      r_cs_s     <= r_cs_meta;
      m_new_data <= w_new_data;
      m_din      <= w_din;
      dev_cs_n   <= w_cs_n;
      ack        <= w_ack;
      done       <= w_done;
      err        <= w_err;
      busy       <= w_busy;
      grant_id   <= w_grant_id;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_arbiter.sv
`default_nettype none
// tb_spi_txn_arbiter: directed scenarios plus random traffic, checked every cycle
// against a deadline-based transaction model of the arbiter.
module tb_spi_txn_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 12;
  localparam int TIMEOUT = 4096;
  localparam int CS_GAP  = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      en_mask;
  logic                 m_cs;
  logic                 m_new_data;
  logic [DW-1:0]        m_din;
  logic [NREQ-1:0]      dev_cs_n;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      done;
  logic [NREQ-1:0]      err;
  logic                 busy;
  logic [1:0]           grant_id;

  spi_txn_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .en_mask(en_mask),
    .m_cs(m_cs), .m_new_data(m_new_data), .m_din(m_din), .dev_cs_n(dev_cs_n),
    .ack(ack), .done(done), .err(err), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int mode  = 0;   // master behaviour: 0 normal, 1 never starts, 2 starts and never ends

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit               mv = 1'b0;
  logic [1:0]       cs_line;
  int               phase;      // 0 free, 1 waiting for master, 2 frame running, 3 quiet gap
  int               deadline, gap_end, last_w;
  logic             e_new, e_busy;
  logic [DW-1:0]    e_din;
  logic [NREQ-1:0]  e_csn, e_ack, e_done, e_err;
  logic [1:0]       e_gid;

  function automatic int pick(input logic [NREQ-1:0] p, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (p[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk) begin
    logic cs_used;
    logic [NREQ-1:0] pend;
    int w;
    cyc++;
    if (rst) begin
      mv = 1'b1; phase = 0; last_w = NREQ - 1; cs_line = 2'b11;
      e_new = 0; e_din = '0; e_csn = '1; e_ack = '0; e_done = '0; e_err = '0;
      e_busy = 0; e_gid = '0;
    end else if (mv) begin
      cs_used = cs_line[1];
      cs_line = {cs_line[0], m_cs};
      e_ack = '0; e_done = '0; e_err = '0;
      case (phase)
        0: begin
          pend = req & en_mask;
          w = pick(pend, last_w);
          if (w >= 0) begin
            last_w = w; e_gid = 2'(w); e_din = req_data[w*DW +: DW];
            e_ack = 4'(1 << w); e_new = 1; e_busy = 1;
            phase = 1; deadline = cyc + TIMEOUT;
          end
        end
        1: begin
          if (!cs_used) begin
            e_new = 0; e_csn = ~4'(1 << e_gid); phase = 2; deadline = cyc + TIMEOUT;
          end else if (cyc == deadline) begin
            e_new = 0; e_err = 4'(1 << e_gid); phase = 3; gap_end = cyc + CS_GAP;
          end
        end
        2: begin
          if (cs_used) begin
            e_csn = '1; e_done = 4'(1 << e_gid); phase = 3; gap_end = cyc + CS_GAP;
          end else if (cyc == deadline) begin
            e_csn = '1; e_err = 4'(1 << e_gid); phase = 3; gap_end = cyc + CS_GAP;
          end
        end
        default: begin
          if (cyc == gap_end) begin e_busy = 0; phase = 0; end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare + grant log ----------------
  int   gq[$];
  logic [DW-1:0] dq[$];
  int   n_ack = 0, n_done = 0;

  always @(negedge clk) begin
    if (mv) begin
      n_cmp++;
      if ({m_new_data, m_din, dev_cs_n, ack, done, err, busy, grant_id} !==
          {e_new, e_din, e_csn, e_ack, e_done, e_err, e_busy, e_gid}) begin
        n_bad++;
        $display("FAIL outputs cycle %0d: got nd=%b din=%h csn=%b ack=%b done=%b err=%b busy=%b gid=%0d want nd=%b din=%h csn=%b ack=%b done=%b err=%b busy=%b gid=%0d",
                 cyc, m_new_data, m_din, dev_cs_n, ack, done, err, busy, grant_id,
                 e_new, e_din, e_csn, e_ack, e_done, e_err, e_busy, e_gid);
      end
      if (ack != 0) begin gq.push_back(int'(grant_id)); dq.push_back(m_din); n_ack++; end
      if (done != 0) n_done++;
    end
  end

  // ---------------- SPI master stand-in ----------------
  initial begin
    int dly, len;
    m_cs = 1'b1;
    forever begin
      @(negedge clk);
      if (rst || mode == 1 || !m_new_data) m_cs = 1'b1;
      else begin
        dly = $urandom_range(0, 4);
        for (int k = 0; k < dly && !rst; k++) @(negedge clk);
        if (!rst) begin
          m_cs = 1'b0;
          if (mode == 2) begin
            while (mode == 2 && !rst) @(negedge clk);
          end else begin
            len = $urandom_range(1, 24);
            for (int k = 0; k < len && !rst; k++) @(negedge clk);
          end
          m_cs = 1'b1;
          while (m_new_data && !rst) @(negedge clk);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    chk(name, busy, 0);
  endtask

  task automatic check_gap_then_idle(input string name);
    repeat (CS_GAP - 1) @(negedge clk);
    chk({name, "_gap_busy"}, {busy, dev_cs_n}, {1'b1, 4'hF});
    @(negedge clk);
    chk({name, "_gap_end"}, {busy, dev_cs_n}, {1'b0, 4'hF});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0;
    bit saw_done;
    rst = 1'b1; req = '0; req_data = '0; en_mask = '1;
    repeat (3) @(negedge clk);
    chk("reset_values", {m_new_data, m_din, dev_cs_n, ack, done, err, busy, grant_id},
        {1'b0, 12'h000, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0});

    // single request
    rst = 1'b0;
    req_data = {12'h333, 12'h222, 12'h111, 12'hA5C};
    req = 4'b0001;
    @(negedge clk);
    chk("single_ack", ack, 4'b0001);
    chk("single_din", m_din, 12'hA5C);
    chk("single_newdata", m_new_data, 1);
    for (int k = 0; k < 100 && dev_cs_n == 4'hF; k++) @(negedge clk);
    chk("single_cs", dev_cs_n, 4'b1110);
    for (int k = 0; k < 100 && done == 0; k++) @(negedge clk);
    chk("single_done", done, 4'b0001);
    req = '0;
    check_gap_then_idle("single");

    // round robin with all four requesting
    do_reset();
    gq.delete(); dq.delete(); n_ack = 0; n_done = 0;
    req_data = {12'hD03, 12'hC02, 12'hB01, 12'hA00};
    req = 4'b1111;
    for (int k = 0; k < 2000 && gq.size() < 5; k++) @(negedge clk);
    req = '0;
    chk("rr_count", gq.size(), 5);
    if (gq.size() >= 5) begin
      chk("rr_order", {gq[0][3:0], gq[1][3:0], gq[2][3:0], gq[3][3:0], gq[4][3:0]}, 20'h01230);
      chk("rr_din1", dq[1], 12'hB01);
      chk("rr_din3", dq[3], 12'hD03);
    end
    wait_idle("rr_idle");
    chk("rr_one_done_per_ack", n_done, n_ack);

    // masking
    do_reset();
    gq.delete();
    req = 4'b0110; en_mask = 4'b0100;
    for (int k = 0; k < 2000 && gq.size() < 3; k++) @(negedge clk);
    chk("mask_count", gq.size(), 3);
    if (gq.size() >= 3) chk("mask_only2", {gq[0][3:0], gq[1][3:0], gq[2][3:0]}, 12'h222);
    en_mask = 4'b0110;
    gq.delete();
    for (int k = 0; k < 500 && gq.size() < 1; k++) @(negedge clk);
    chk("mask_next", gq.size() >= 1 ? gq[0] : -1, 1);
    req = '0;
    en_mask = '1;
    wait_idle("mask_idle");

    // master never starts: timeout in launch
    mode = 1;
    req = 4'b1000;
    for (int k = 0; k < 20 && ack == 0; k++) @(negedge clk);
    chk("to_ack", ack, 4'b1000);
    t0 = cyc; saw_done = 0;
    for (int k = 0; k < TIMEOUT + 50 && err == 0; k++) begin
      @(negedge clk);
      if (done != 0) saw_done = 1;
    end
    chk("to_err", err, 4'b1000);
    chk("to_len", cyc - t0, TIMEOUT);
    chk("to_newdata", m_new_data, 0);
    chk("to_no_done", saw_done, 0);
    req = '0; mode = 0;
    check_gap_then_idle("to");

    // reset during a frame
    mode = 2;
    req = 4'b0100;
    for (int k = 0; k < 100 && dev_cs_n != 4'b1011; k++) @(negedge clk);
    chk("rx_cs", dev_cs_n, 4'b1011);
    rst = 1'b1;
    @(negedge clk);
    chk("rx_reset_values", {m_new_data, m_din, dev_cs_n, ack, done, err, busy, grant_id},
        {1'b0, 12'h000, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0});
    mode = 0; rst = 1'b0;
    @(negedge clk);
    chk("rx_regrant", {ack, grant_id}, {4'b0100, 2'd2});
    for (int k = 0; k < 200 && done == 0; k++) @(negedge clk);
    req = '0;
    chk("rx_done", done, 4'b0100);
    wait_idle("rx_idle");

    // master starts and never ends: timeout in xfer
    repeat (4) @(negedge clk);
    mode = 2;
    req = 4'b0001;
    for (int k = 0; k < 100 && dev_cs_n == 4'hF; k++) @(negedge clk);
    chk("sl_cs", dev_cs_n, 4'b1110);
    t0 = cyc;
    for (int k = 0; k < TIMEOUT + 50 && err == 0; k++) @(negedge clk);
    chk("sl_err", {err, dev_cs_n, done}, {4'b0001, 4'hF, 4'h0});
    chk("sl_len", cyc - t0, TIMEOUT);
    mode = 0; req = '0;
    wait_idle("sl_idle");
    repeat (4) @(negedge clk);

    // random traffic
    for (int c = 0; c < 12000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 63) == 0)
        en_mask = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '1;
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if ((done[i] || err[i]) && $urandom_range(0, 1) == 1) req[i] = 1'b0;
          else if ($urandom_range(0, 199) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b1;
          req_data[i*DW +: DW] = DW'($urandom);
        end
      end
    end
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Shares one 12-bit SPI master core between NREQ requesters using round-robin arbitration.
- Latches the winning requester's frame and drives the master's new_data/din.
- Tracks frame completion from the master's cs output and steers a per-device active-low chip select.
- Reports completion or timeout back to the requester.
- Sits between the system-side requesters and the SPI master/slave pair.

Parameters:
- NREQ, 4, number of requesters/devices (2..8).
- DW, 12, frame width; must match the master's din width.
- TIMEOUT, 4096, clk cycles allowed in LAUNCH or XFER before abort.
- CS_GAP, 4, minimum clk cycles all dev_cs_n stay high between frames.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level; held until done or err pulse
- req_data  in  NREQ*DW  frame per requester; slice i = bits [i*DW +: DW]
- en_mask  in  NREQ  requester enable; masked requests are ignored
- m_cs  in  1  master cs output (high = idle)
- m_new_data  out  1  start strobe to master
- m_din  out  DW  frame to master
- dev_cs_n  out  NREQ  per-device active-low chip select
- ack  out  NREQ  1-cycle pulse: request granted, data latched
- done  out  NREQ  1-cycle pulse: frame completed
- err  out  NREQ  1-cycle pulse: frame aborted by timeout
- busy  out  1  high in any state except IDLE
- grant_id  out  $clog2(NREQ)  index of current or last grant

Behaviour:
- Reset values (all outputs registered):
  - m_new_data=0, m_din=0, dev_cs_n=all 1s.
  - ack/done/err=0, busy=0, grant_id=0.
  - rr_ptr=NREQ-1, so requester 0 wins first; state=IDLE.
- rst mid-operation forces reset values on the next edge. The master shares rst; no done/err is produced for the aborted frame.
- m_cs passes through a 2-flop synchronizer (cs_s). All decisions use cs_s, which adds 2 clk cycles of latency.
- pending = req & en_mask.
- Arbitration:
  - The winner is the first set bit of pending, searching from rr_ptr+1 upward with wrap-around.
  - rr_ptr is updated to the winner on grant.
  - A requester holding req high after done re-arbitrates behind all other pending requesters.
- IDLE, when pending is nonzero:
  - Next edge: grant_id<=winner, m_din<=req_data slice, ack[winner]<=1 for one cycle, m_new_data<=1, busy<=1, go to LAUNCH.
  - Grant latency is 1 cycle from req visible to ack/m_new_data high.
- LAUNCH:
  - m_new_data stays high until cs_s==0.
  - On cs_s==0: m_new_data<=0, dev_cs_n[grant_id]<=0, go to XFER.
- XFER:
  - On cs_s==1: dev_cs_n<=all 1s, done[grant_id]<=1 for one cycle, go to GAP.
- GAP:
  - Count CS_GAP cycles, then go to IDLE with busy<=0.
  - busy stays high during GAP; requests are not arbitrated during GAP.
- Timeout:
  - A cycle counter resets on entry to LAUNCH and to XFER.
  - On reaching TIMEOUT-1 in either state: m_new_data<=0, dev_cs_n<=all 1s, err[grant_id]<=1 for one cycle, go to GAP.
  - done is not pulsed on timeout.
- Simultaneous events:
  - At most one of done/err fires per grant.
  - ack never coincides with done or err.
  - A requester's req dropping after ack does not cancel the frame; the data is already latched.
  - en_mask changes affect only future arbitration.
- Only one dev_cs_n bit may be low at any time. All bits are high outside XFER.
- m_din stays stable from ack until the next grant.

Test Plan:
- Single request: rst then req=0001, req_data[0]=12'hA5C, master running -> ack[0] one cycle later, m_din=12'hA5C, dev_cs_n=1110 during frame, done[0] pulse, then dev_cs_n=1111 for ≥4 cycles.
- Round-robin: req=1111 held continuously with distinct data -> grant order 0,1,2,3,0; each m_din matches its slice; exactly one done per ack.
- Masking: req=0110, en_mask=0100 -> only requester 2 served; requester 1 never acked until en_mask=0110, then served next.
- Timeout: m_cs tied high, req=1000 -> ack[3], m_new_data high for 4096 cycles, then err[3] pulse, m_new_data=0, no done, returns to IDLE after GAP.
- Reset mid-XFER: assert rst while dev_cs_n=1011 -> next edge all outputs at reset values, no done/err. After release with req=0100 still high, a fresh grant to requester 2 (rr_ptr reset).
- Stuck-low cs: m_cs falls then never rises -> err pulse exactly TIMEOUT cycles after XFER entry, dev_cs_n=all 1s.
